// File: rtl/line_dram.sv
// Latency-modelled line-granular backing store for the data cache.
// One request at a time: accept in IDLE, count down in BUSY, pulse mem_ready in DONE.
module line_dram #(
  parameter int unsigned AWIDTH    = 6,
  parameter int unsigned DWIDTH    = 128,
  parameter int unsigned MEM_DEPTH = 2**AWIDTH,
  parameter int unsigned LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic              rden,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   din_q;
  logic                wr_q;
  logic                accept;
  logic                rd_load;
  logic                wr_commit;

  logic [DWIDTH-1:0]   mem [MEM_DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (wren || rden) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          rd_load = ~wr_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        wr_commit = wr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_ready = (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      data_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= addr;
        din_q  <= data_in;
        // write wins when both requests arrive together
        wr_q   <= wren;
      end
      if (rd_load) begin
        data_out <= mem[addr_q];
      end
    end
  end

  // Array is deliberately outside the reset domain; reset forces IDLE so a
  // pending write can never reach this port.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[addr_q] <= din_q;
    end
  end

endmodule

// File: tb/tb_line_dram.sv
// Scoreboard bench for line_dram: a LATENCY=4 instance for the functional
// sequence and a LATENCY=1 instance for back-to-back held reads.
module tb_line_dram;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 128;
  localparam int unsigned LAT_A = 4;
  localparam int unsigned LAT_B = 1;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_wren, a_rden, a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din, a_dout;
  logic          b_wren, b_rden, b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din, b_dout;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        qa[$];
  exp_t        qb[$];

  localparam logic [DW-1:0] V1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] V5   = {8{16'h5555}};
  localparam logic [DW-1:0] VA   = {8{16'hAAAA}};
  localparam logic [DW-1:0] VD   = {8{16'hDEAD}};
  localparam logic [DW-1:0] VC   = {8{16'hC0FE}};
  localparam logic [DW-1:0] V11  = {8{16'h1111}};
  localparam logic [DW-1:0] V22  = {8{16'h2222}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_dram #(.AWIDTH(AW), .DWIDTH(DW), .MEM_DEPTH(2**AW), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .wren(a_wren), .rden(a_rden), .addr(a_addr),
    .data_in(a_din), .data_out(a_dout), .mem_ready(a_ready)
  );

  line_dram #(.AWIDTH(AW), .DWIDTH(DW), .MEM_DEPTH(2**AW), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .wren(b_wren), .rden(b_rden), .addr(b_addr),
    .data_in(b_din), .data_out(b_dout), .mem_ready(b_ready)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every mem_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (a_ready !== 1'b0) begin
      if (qa.size() == 0) begin
        chk("a_spurious_ready", DW'(a_ready), '0);
      end else begin
        e = qa.pop_front();
        chk("a_ready_cycle", DW'(cyc), DW'(e.cyc));
        chk("a_data_out", a_dout, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_ready !== 1'b0) begin
      if (qb.size() == 0) begin
        chk("b_spurious_ready", DW'(b_ready), '0);
      end else begin
        e = qb.pop_front();
        chk("b_ready_cycle", DW'(cyc), DW'(e.cyc));
        chk("b_data_out", b_dout, e.data);
      end
    end
  end

  // Issue one request on DUT A, drop it after acceptance, wait until IDLE.
  task automatic req_a(input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp, input bit scramble);
    @(negedge clk);
    a_wren = wr;
    a_rden = rd;
    a_addr = a;
    a_din  = d;
    qa.push_back(exp_t'{cyc + 1 + LAT_A, exp});
    @(negedge clk);
    a_wren = 1'b0;
    a_rden = 1'b0;
    if (scramble) begin
      a_addr = ~a;
      a_din  = ~d;
    end
    repeat (LAT_A + 1) @(negedge clk);
  endtask

  initial begin
    int unsigned c0;
    rst    = 1'b0;
    a_wren = 1'b0; a_rden = 1'b0; a_addr = '0; a_din = '0;
    b_wren = 1'b0; b_rden = 1'b0; b_addr = '0; b_din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", DW'(a_ready), '0);
    chk("reset_data_out", a_dout, '0);

    req_a(1'b0, 1'b1, 6'h05, '0,  '0, 1'b0);
    req_a(1'b1, 1'b0, 6'h2A, V1,  '0, 1'b0);
    req_a(1'b0, 1'b1, 6'h2A, '0,  V1, 1'b0);
    req_a(1'b1, 1'b0, 6'h0F, V5,  V1, 1'b0);
    req_a(1'b1, 1'b0, 6'h3F, VA,  V1, 1'b0);
    req_a(1'b0, 1'b1, 6'h0F, '0,  V5, 1'b0);
    req_a(1'b0, 1'b1, 6'h3F, '0,  VA, 1'b0);
    req_a(1'b1, 1'b1, 6'h10, VD,  VA, 1'b0);
    req_a(1'b0, 1'b1, 6'h10, '0,  VD, 1'b0);
    req_a(1'b1, 1'b0, 6'h20, VC,  VD, 1'b1);
    req_a(1'b0, 1'b1, 6'h20, '0,  VC, 1'b0);
    req_a(1'b0, 1'b1, 6'h1F, '0,  '0, 1'b0);
    req_a(1'b1, 1'b0, 6'h07, V11, '0, 1'b0);

    // Write to 0x07 interrupted by reset two cycles in: no pulse, no commit.
    @(negedge clk);
    a_wren = 1'b1; a_addr = 6'h07; a_din = V22;
    @(negedge clk);
    a_wren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_ready", DW'(a_ready), '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT_A + 3) @(negedge clk);
    chk("post_reset_data_out", a_dout, '0);

    req_a(1'b0, 1'b1, 6'h07, '0, V11, 1'b0);
    req_a(1'b0, 1'b1, 6'h2A, '0, V1,  1'b0);

    // LATENCY=1 instance: held read pulses every 3 cycles.
    @(negedge clk);
    b_rden = 1'b1;
    b_addr = 6'h03;
    c0 = cyc;
    for (int unsigned k = 0; k < 4; k++) begin
      qb.push_back(exp_t'{c0 + 1 + LAT_B + 3 * k, '0});
    end
    repeat (11) @(negedge clk);
    b_rden = 1'b0;
    repeat (6) @(negedge clk);

    chk("a_outstanding", DW'(qa.size()), '0);
    chk("b_outstanding", DW'(qb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
